// File: rtl/kontroler_przerwan.sv
// Interrupt controller: latches peripheral pulses into pending bits, arbitrates by fixed
// priority (index 0 highest) and runs the request/acknowledge/done handshake with the CPU.
module kontroler_przerwan #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [7:0]       wartosc,
    input  logic             zapisz_ctr,
    input  logic             zapisz_clr,
    output logic             irq_req,
    output logic [2:0]       irq_vec,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic [N_SRC-1:0] flaga_clear,
    output logic [N_SRC-1:0] pending,
    output logic             w_obsludze
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] enable_next;
    logic             global_en;
    logic             global_next;

    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] flaga_next;
    logic             req_next;
    logic [2:0]       vec_next;

    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] vec_onehot;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] clr_mask;
    logic [2:0]       winner;
    logic             any_eligible;
    logic             clr_write;
    logic             vec_cleared;

    assign eligible   = pending & enable & {N_SRC{global_en}};
    assign w_obsludze = (state == SERVICE);

    // Descending scan: the last hit written is the lowest index, i.e. the highest priority.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = 3'(i);
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        vec_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            vec_onehot[i] = (irq_vec == 3'(i));
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_next  = state;
        req_next    = irq_req;
        vec_next    = irq_vec;
        flaga_next  = '0;
        ack_mask    = '0;

        // A control write shadows the clear strobe in the same cycle.
        clr_write   = zapisz_clr && !zapisz_ctr;
        enable_next = zapisz_ctr ? wartosc[N_SRC-1:0] : enable;
        global_next = zapisz_ctr ? wartosc[7] : global_en;

        // The served bit only counts as cleared when no new pulse re-sets it this cycle.
        vec_cleared = clr_write && |(wartosc[N_SRC-1:0] & vec_onehot & ~irq_in);

        unique case (state)
            IDLE: begin
                if (any_eligible) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    vec_next   = winner;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_next = SERVICE;
                    req_next   = 1'b0;
                    ack_mask   = vec_onehot;
                    flaga_next = vec_onehot;
                end else if (!global_next || vec_cleared) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase

        clr_mask     = ack_mask | (clr_write ? wartosc[N_SRC-1:0] : '0);
        pending_next = (pending & ~clr_mask) | irq_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
            state       <= IDLE;
            irq_req     <= 1'b0;
            irq_vec     <= '0;
            flaga_clear <= '0;
            pending     <= '0;
            enable      <= '0;
            global_en   <= 1'b0;
        end else begin
            state       <= state_next;
            irq_req     <= req_next;
            irq_vec     <= vec_next;
            flaga_clear <= flaga_next;
            pending     <= pending_next;
            enable      <= enable_next;
            global_en   <= global_next;
        end
    end

endmodule

// File: tb/tb_kontroler_przerwan.sv
// Self-checking bench for kontroler_przerwan: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_kontroler_przerwan;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_in;
    logic [7:0]   wartosc;
    logic         zapisz_ctr;
    logic         zapisz_clr;
    logic         irq_req;
    logic [2:0]   irq_vec;
    logic         irq_ack;
    logic         irq_done;
    logic [N-1:0] flaga_clear;
    logic [N-1:0] pending;
    logic         w_obsludze;

    int n_checks = 0;
    int n_pass   = 0;

    kontroler_przerwan #(.N_SRC(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .wartosc     (wartosc),
        .zapisz_ctr  (zapisz_ctr),
        .zapisz_clr  (zapisz_clr),
        .irq_req     (irq_req),
        .irq_vec     (irq_vec),
        .irq_ack     (irq_ack),
        .irq_done    (irq_done),
        .flaga_clear (flaga_clear),
        .pending     (pending),
        .w_obsludze  (w_obsludze)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = waiting for work, 1 = request outstanding, 2 = CPU in handler.
    bit           model_valid = 1'b0;
    int           m_phase;
    int           m_vec;
    bit           m_req;
    bit           m_glob;
    bit [N-1:0]   m_pend;
    bit [N-1:0]   m_en;
    bit [N-1:0]   m_flaga;

    always @(posedge clk) begin
        bit [N-1:0] clr;
        bit         glob_after;
        int         best;
        if (rst) begin
            model_valid = 1'b1;
            m_phase = 0;
            m_vec   = 0;
            m_req   = 1'b0;
            m_glob  = 1'b0;
            m_pend  = '0;
            m_en    = '0;
            m_flaga = '0;
        end else begin
            clr        = (zapisz_clr && !zapisz_ctr) ? wartosc[N-1:0] : '0;
            glob_after = zapisz_ctr ? wartosc[7] : m_glob;
            m_flaga    = '0;
            if (m_phase == 0) begin
                best = -1;
                if (m_glob) begin
                    for (int i = N - 1; i >= 0; i--) begin
                        if (m_pend[i] && m_en[i]) best = i;
                    end
                end
                if (best >= 0) begin
                    m_req   = 1'b1;
                    m_vec   = best;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (irq_ack) begin
                    clr[m_vec]     = 1'b1;
                    m_flaga[m_vec] = 1'b1;
                    m_req   = 1'b0;
                    m_phase = 2;
                end else if (!glob_after || (clr[m_vec] && !irq_in[m_vec])) begin
                    m_req   = 1'b0;
                    m_phase = 0;
                end
            end else begin
                if (irq_done) m_phase = 0;
            end
            m_pend = (m_pend & ~clr) | irq_in;
            if (zapisz_ctr) begin
                m_en   = wartosc[N-1:0];
                m_glob = wartosc[7];
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model irq_req", 32'(irq_req), 32'(m_req));
            check("model pending", 32'(pending), 32'(m_pend));
            check("model flaga_clear", 32'(flaga_clear), 32'(m_flaga));
            check("model w_obsludze", 32'(w_obsludze), 32'(m_phase == 2));
            if (m_req) check("model irq_vec", 32'(irq_vec), 32'(m_vec));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        irq_in     = '0;
        wartosc    = '0;
        zapisz_ctr = 1'b0;
        zapisz_clr = 1'b0;
        irq_ack    = 1'b0;
        irq_done   = 1'b0;
    endtask

    task automatic write_ctr(input logic [7:0] v);
        wartosc = v; zapisz_ctr = 1'b1;
        tick();
        zapisz_ctr = 1'b0; wartosc = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("reset irq_req", 32'(irq_req), 32'd0);
        check("reset irq_vec", 32'(irq_vec), 32'd0);
        check("reset pending", 32'(pending), 32'd0);
        check("reset flaga_clear", 32'(flaga_clear), 32'd0);
        check("reset w_obsludze", 32'(w_obsludze), 32'd0);
        rst = 1'b0;

        // Basic request / ack / done
        write_ctr(8'h81);
        irq_in = 4'b0001; tick(); irq_in = '0;
        check("basic pending t+1", 32'(pending), 32'h1);
        check("basic req t+1", 32'(irq_req), 32'd0);
        tick();
        check("basic req t+2", 32'(irq_req), 32'd1);
        check("basic vec", 32'(irq_vec), 32'd0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("basic req after ack", 32'(irq_req), 32'd0);
        check("basic pending after ack", 32'(pending), 32'h0);
        check("basic flaga", 32'(flaga_clear), 32'h1);
        check("basic service", 32'(w_obsludze), 32'd1);
        tick();
        check("basic flaga one cycle", 32'(flaga_clear), 32'h0);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        check("basic back to idle", 32'(w_obsludze), 32'd0);

        // Priority, and re-arbitration two cycles after done
        write_ctr(8'h87);
        irq_in = 4'b0110; tick(); irq_in = '0;
        tick();
        check("prio req", 32'(irq_req), 32'd1);
        check("prio vec", 32'(irq_vec), 32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("prio pending", 32'(pending), 32'h4);
        check("prio flaga", 32'(flaga_clear), 32'h2);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        check("prio req 1 after done", 32'(irq_req), 32'd0);
        tick();
        check("prio req 2 after done", 32'(irq_req), 32'd1);
        check("prio second vec", 32'(irq_vec), 32'd2);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;

        // Masking, then enabling
        write_ctr(8'h02);
        irq_in = 4'b0001; tick(); irq_in = '0;
        check("mask pending", 32'(pending), 32'h1);
        tick();
        check("mask no req", 32'(irq_req), 32'd0);
        write_ctr(8'h83);
        check("unmask req +1", 32'(irq_req), 32'd0);
        tick();
        check("unmask req +2", 32'(irq_req), 32'd1);
        check("unmask vec", 32'(irq_vec), 32'd0);

        // Global disable withdraws the outstanding request
        write_ctr(8'h01);
        check("gdis req", 32'(irq_req), 32'd0);
        check("gdis pending", 32'(pending), 32'h1);
        check("gdis flaga", 32'(flaga_clear), 32'h0);
        check("gdis not service", 32'(w_obsludze), 32'd0);
        tick();
        check("gdis stays idle", 32'(irq_req), 32'd0);

        // Set wins over ack clear
        write_ctr(8'h81);
        tick();
        check("race req", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; irq_in = 4'b0001; tick(); irq_ack = 1'b0; irq_in = '0;
        check("race flaga", 32'(flaga_clear), 32'h1);
        check("race pending kept", 32'(pending), 32'h1);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick();
        check("race re-request", 32'(irq_req), 32'd1);
        check("race re-request vec", 32'(irq_vec), 32'd0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;

        // W1C, control write shadowing a clear, reset during service
        write_ctr(8'h00);
        irq_in = 4'b0101; tick(); irq_in = '0;
        check("w1c before", 32'(pending), 32'h5);
        wartosc = 8'h04; zapisz_clr = 1'b1; tick(); zapisz_clr = 1'b0; wartosc = '0;
        check("w1c after", 32'(pending), 32'h1);
        wartosc = 8'h01; zapisz_clr = 1'b1; zapisz_ctr = 1'b1; tick();
        zapisz_clr = 1'b0; zapisz_ctr = 1'b0; wartosc = '0;
        check("ctr shadows clr", 32'(pending), 32'h1);
        write_ctr(8'h81);
        tick();
        check("rst test req", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("rst test service", 32'(w_obsludze), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid rst req", 32'(irq_req), 32'd0);
        check("mid rst pending", 32'(pending), 32'h0);
        check("mid rst flaga", 32'(flaga_clear), 32'h0);
        check("mid rst service", 32'(w_obsludze), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            irq_in     = N'($urandom) & N'($urandom) & N'($urandom);
            zapisz_ctr = ($urandom_range(0, 19) == 0);
            zapisz_clr = ($urandom_range(0, 14) == 0);
            wartosc    = 8'($urandom);
            if (zapisz_ctr && $urandom_range(0, 3) != 0) wartosc[7] = 1'b1;
            irq_ack    = ($urandom_range(0, 2) == 0);
            irq_done   = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
